// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control/register stage.
// Holds A, D and the PC, decodes the current instruction into ALU operands
// and control, then uses the same-cycle ALU result for writeback, memory
// write and jump resolution. A write to data RAM that is not accepted
// immediately parks the core in WAIT_MEM until mem_ready arrives.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal execution, one instruction per valid cycle
// WAIT_MEM | C-instruction with d[M] accepted, write pending on mem_ready

module hack_cpu_ctrl #(
  parameter int unsigned    PC_W     = 15,
  parameter logic [PC_W-1:0] PC_RESET = 15'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instruction,
  input  logic            instr_valid,
  input  logic [15:0]     inM,
  input  logic            mem_ready,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] addressM,
  output logic [15:0]     outM,
  output logic            writeM,
  output logic [15:0]     alu_x,
  output logic [15:0]     alu_y,
  output logic [5:0]      alu_ctl,
  input  logic [15:0]     alu_out,
  input  logic            alu_zr,
  input  logic            alu_ng
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [15:0]     a_reg;
  logic [15:0]     d_reg;
  logic [PC_W-1:0] pc_reg;

  // Instruction fields. Bits 14:13 of a C-instruction carry no meaning.
  logic       is_c;
  logic       sel_m;
  logic [2:0] dest;
  logic [2:0] jmp;
  logic       jump;

  // Control decisions for the register update.
  logic load_a_instr;
  logic commit;

  // Field decode and jump condition from the ALU flags of this cycle.
  always_comb begin
    is_c  = instruction[15];
    sel_m = instruction[12];
    dest  = instruction[5:3];
    jmp   = instruction[2:0];
    jump  = (jmp[2] & alu_ng) |
            (jmp[1] & alu_zr) |
            (jmp[0] & ~alu_zr & ~alu_ng);
  end

  // ALU operand and control drive; purely a function of instruction and state.
  always_comb begin
    alu_x   = d_reg;
    alu_y   = (is_c && sel_m) ? inM : a_reg;
    alu_ctl = is_c ? instruction[11:6] : 6'b0;
  end

  // Memory-side outputs. The address is always the pre-writeback A so that
  // AM=... style instructions write to the old location.
  assign addressM = a_reg[PC_W-1:0];
  assign outM     = alu_out;
  assign pc       = pc_reg;

  // Next-state and commit decisions.
  always_comb begin
    state_next   = state;
    load_a_instr = 1'b0;
    commit       = 1'b0;
    writeM       = 1'b0;
    unique case (state)
      RUN: begin
        if (instr_valid) begin
          if (!is_c) begin
            load_a_instr = 1'b1;
          end else if (dest[0]) begin
            writeM = 1'b1;
            if (mem_ready) commit = 1'b1;
            else           state_next = WAIT_MEM;
          end else begin
            commit = 1'b1;
          end
        end
      end
      WAIT_MEM: begin
        // The instruction was accepted on entry; instr_valid no longer matters.
        writeM = 1'b1;
        if (mem_ready) begin
          commit     = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // A, D and PC update. Jump target uses the A value read this cycle, before
  // any writeback of the same instruction lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg  <= 16'd0;
      d_reg  <= 16'd0;
      pc_reg <= PC_RESET;
    end else if (load_a_instr) begin
      a_reg  <= instruction;
      pc_reg <= pc_reg + 1'b1;
    end else if (commit) begin
      if (dest[2]) a_reg <= alu_out;
      if (dest[1]) d_reg <= alu_out;
      pc_reg <= jump ? a_reg[PC_W-1:0] : pc_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Bench for hack_cpu_ctrl: a behavioural Hack ALU closes the loop, expected
// post-edge state is queued when each instruction is driven and compared
// once the edge has committed it.

module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] inM;
  logic        mem_ready;
  logic [14:0] pc;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       tag;
    logic [14:0] pc;
    logic [14:0] addr;
    logic [15:0] d;
    logic        wr;
  } exp_t;

  exp_t exp_q[$];

  hack_cpu_ctrl #(.PC_RESET(15'd0)) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .inM         (inM),
    .mem_ready   (mem_ready),
    .pc          (pc),
    .addressM    (addressM),
    .outM        (outM),
    .writeM      (writeM),
    .alu_x       (alu_x),
    .alu_y       (alu_y),
    .alu_ctl     (alu_ctl),
    .alu_out     (alu_out),
    .alu_zr      (alu_zr),
    .alu_ng      (alu_ng)
  );

  always #5 clk = ~clk;

  // Reference Hack ALU.
  always_comb begin
    logic [15:0] x, y, r;
    x = alu_ctl[5] ? 16'd0 : alu_x;
    x = alu_ctl[4] ? ~x : x;
    y = alu_ctl[3] ? 16'd0 : alu_y;
    y = alu_ctl[2] ? ~y : y;
    r = alu_ctl[1] ? (x + y) : (x & y);
    r = alu_ctl[0] ? ~r : r;
    alu_out = r;
    alu_zr  = (r == 16'd0);
    alu_ng  = r[15];
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Drive one cycle of stimulus and queue the state expected after the edge.
  task automatic drive(input logic rst, input logic [15:0] ins, input logic vld,
                       input logic [15:0] m, input logic rdy, input string tag,
                       input logic [14:0] e_pc, input logic [14:0] e_addr,
                       input logic [15:0] e_d, input logic e_wr);
    exp_t e;
    reset       = rst;
    instruction = ins;
    instr_valid = vld;
    inM         = m;
    mem_ready   = rdy;
    e.tag = tag; e.pc = e_pc; e.addr = e_addr; e.d = e_d; e.wr = e_wr;
    exp_q.push_back(e);
    #1;
  endtask

  // Clock the queued cycle, idle the inputs, then compare committed state.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    instr_valid = 1'b0;
    mem_ready   = 1'b0;
    #1;
    if (exp_q.size() == 0) begin
      chk("queue_empty", 16'd0, 16'd1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_pc"},   {1'b0, pc},       {1'b0, e.pc});
      chk({e.tag, "_addr"}, {1'b0, addressM}, {1'b0, e.addr});
      chk({e.tag, "_d"},    alu_x,            e.d);
      chk({e.tag, "_wr"},   {15'd0, writeM},  {15'd0, e.wr});
    end
  endtask

  initial begin
    reset = 1'b1; instruction = 16'd0; instr_valid = 1'b0; inM = 16'd0; mem_ready = 1'b0;
    @(posedge clk); #1;

    drive(1, 16'h0000, 0, 0, 0, "reset", 15'd0, 15'd0, 16'd0, 0); tick();

    drive(0, 16'h1234, 1, 0, 0, "a1234", 15'd1, 15'h1234, 16'd0, 0);
    chk("a_ctl", {10'd0, alu_ctl}, 16'd0);
    chk("a_wr",  {15'd0, writeM},  16'd0);
    tick();

    drive(0, 16'h0005, 1, 0, 0, "a5", 15'd2, 15'd5, 16'd0, 0); tick();
    drive(0, 16'hEC10, 1, 0, 0, "d_eq_a", 15'd3, 15'd5, 16'd5, 0);
    chk("deqa_ctl", {10'd0, alu_ctl}, 16'h0030);
    chk("deqa_x",   alu_x, 16'd0);
    chk("deqa_y",   alu_y, 16'd5);
    tick();

    drive(0, 16'h0007, 1, 0, 0, "a7",   15'd4, 15'd7,   16'd5, 0); tick();
    drive(0, 16'hEC10, 1, 0, 0, "d7",   15'd5, 15'd7,   16'd7, 0); tick();
    drive(0, 16'd100,  1, 0, 0, "a100", 15'd6, 15'd100, 16'd7, 0); tick();

    for (int i = 0; i < 4; i++) begin
      drive(0, 16'hE308, 1, 16'h0055, (i == 3), "m_eq_d",
            (i == 3) ? 15'd7 : 15'd6, 15'd100, 16'd7, (i != 3));
      chk("meqd_wr",   {15'd0, writeM},   16'd1);
      chk("meqd_addr", {1'b0, addressM},  16'd100);
      chk("meqd_out",  outM,              16'd7);
      tick();
    end

    drive(0, 16'hEA90, 1, 0, 0, "d0",   15'd8,  15'd100, 16'd0, 0); tick();
    drive(0, 16'd42,   1, 0, 0, "a42",  15'd9,  15'd42,  16'd0, 0); tick();
    drive(0, 16'hE302, 1, 0, 0, "jeq_taken", 15'd42, 15'd42, 16'd0, 0); tick();
    drive(0, 16'd3,    1, 0, 0, "a3",   15'd43, 15'd3,   16'd0, 0); tick();
    drive(0, 16'hEC10, 1, 0, 0, "d3",   15'd44, 15'd3,   16'd3, 0); tick();
    drive(0, 16'd42,   1, 0, 0, "a42b", 15'd45, 15'd42,  16'd3, 0); tick();
    drive(0, 16'hE302, 1, 0, 0, "jeq_not", 15'd46, 15'd42, 16'd3, 0); tick();
    drive(0, 16'hEE90, 1, 0, 0, "dm1",  15'd47, 15'd42,  16'hFFFF, 0); tick();
    drive(0, 16'd42,   1, 0, 0, "a42c", 15'd48, 15'd42,  16'hFFFF, 0); tick();
    drive(0, 16'hE304, 1, 0, 0, "jlt_taken", 15'd42, 15'd42, 16'hFFFF, 0); tick();
    drive(0, 16'd42,   1, 0, 0, "a42d", 15'd43, 15'd42,  16'hFFFF, 0); tick();
    drive(0, 16'hEA87, 1, 0, 0, "jmp",  15'd42, 15'd42,  16'hFFFF, 0); tick();

    drive(0, 16'd9,    1, 0, 0, "a9",   15'd43, 15'd9,   16'hFFFF, 0); tick();
    drive(0, 16'hFDEF, 1, 16'h0020, 1, "am_jmp", 15'd9, 15'h0021, 16'hFFFF, 0);
    chk("amj_wr",   {15'd0, writeM},  16'd1);
    chk("amj_addr", {1'b0, addressM}, 16'd9);
    chk("amj_y",    alu_y,            16'h0020);
    chk("amj_out",  outM,             16'h0021);
    tick();

    drive(0, 16'h7FFF, 1, 0, 0, "a7fff",  15'd10,    15'h7FFF, 16'hFFFF, 0); tick();
    drive(0, 16'hEA87, 1, 0, 0, "jmp_top", 15'h7FFF, 15'h7FFF, 16'hFFFF, 0); tick();
    drive(0, 16'd5,    1, 0, 0, "pc_wrap", 15'd0,    15'd5,    16'hFFFF, 0); tick();

    for (int i = 0; i < 2; i++) begin
      drive(0, 16'hEC10, 0, 0, 1, "idle", 15'd0, 15'd5, 16'hFFFF, 0);
      chk("idle_wr", {15'd0, writeM}, 16'd0);
      tick();
    end

    drive(0, 16'd100,  1, 0, 0, "a100b", 15'd1, 15'd100, 16'hFFFF, 0); tick();
    drive(0, 16'hE308, 1, 0, 0, "m_stall", 15'd1, 15'd100, 16'hFFFF, 1); tick();
    drive(1, 16'hE308, 0, 0, 0, "rst_wait", 15'd0, 15'd0, 16'd0, 0); tick();

    chk("queue_drained", exp_q.size()[15:0], 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
